// File: rtl/ajuste_pkg.sv
// rtl/ajuste_pkg.sv - shared FSM state type and timer sizing for control_ajuste_valor
package ajuste_pkg;

    typedef enum logic {
        REPOSO  = 1'b0,
        EDICION = 1'b1
    } estado_t;

    // Bits needed to count 0 .. n-1, i.e. ceil(log2(n)); never narrower than 1 bit
    function automatic int ancho_timer(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/paso_acotado.sv
// rtl/paso_acotado.sv - combinational +/-1 step bounded to [VALOR_MIN, VALOR_MAX]; WRAP_AROUND_EN selects wrap instead of saturate
module paso_acotado #(
    parameter int ANCHO     = 8,
    parameter int VALOR_MIN = 0,
    parameter int VALOR_MAX = 59
) (
    input  logic [ANCHO-1:0] valor,
    input  logic             subir,
    output logic [ANCHO-1:0] resultado
);

    // One extra bit so neither the compare nor the +1 can overflow
    localparam logic [ANCHO:0] MIN_EXT = (ANCHO + 1)'(VALOR_MIN);
    localparam logic [ANCHO:0] MAX_EXT = (ANCHO + 1)'(VALOR_MAX);

    logic [ANCHO:0] valor_ext;
    logic [ANCHO:0] paso_ext;

    assign valor_ext = {1'b0, valor};

    // Edge tests happen before the arithmetic, so the decrement never goes below zero
    always_comb begin
        paso_ext = valor_ext;
        if (subir) begin
            if (valor_ext >= MAX_EXT) begin
`ifdef WRAP_AROUND_EN
                paso_ext = MIN_EXT;
`else
                paso_ext = MAX_EXT;
`endif
            end else begin
                paso_ext = valor_ext + 1'b1;
            end
        end else begin
            if (valor_ext <= MIN_EXT) begin
`ifdef WRAP_AROUND_EN
                paso_ext = MAX_EXT;
`else
                paso_ext = MIN_EXT;
`endif
            end else begin
                paso_ext = valor_ext - 1'b1;
            end
        end
    end

    assign resultado = paso_ext[ANCHO-1:0];

endmodule

// File: rtl/control_ajuste_valor.sv
// rtl/control_ajuste_valor.sv - edit/commit FSM for a bounded setting with inactivity timeout (WRAP_AROUND_EN in paso_acotado)
module control_ajuste_valor
    import ajuste_pkg::*;
#(
    parameter int ANCHO          = 8,
    parameter int VALOR_MIN      = 0,
    parameter int VALOR_MAX      = 59,
    parameter int VALOR_RESET    = 0,
    parameter int TIMEOUT_CICLOS = 100000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             aumentar,
    input  logic             disminuir,
    input  logic             confirmar,
    output logic [ANCHO-1:0] valor_actual,
    output logic [ANCHO-1:0] valor_edit,
    output logic             editando,
    output logic             actualizado
);

    localparam int                TW        = ancho_timer(TIMEOUT_CICLOS);
    localparam logic [TW-1:0]     TIMER_FIN = TW'(TIMEOUT_CICLOS - 1);
    localparam logic [ANCHO-1:0]  RESET_V   = ANCHO'(VALOR_RESET);

    estado_t          estado_q, estado_sig;
    logic [ANCHO-1:0] actual_q, actual_sig;
    logic [ANCHO-1:0] edit_q, edit_sig;
    logic [TW-1:0]    timer_q, timer_sig;
    logic             act_q, act_sig;

    logic             evento;
    logic [ANCHO-1:0] base_paso;
    logic [ANCHO-1:0] valor_paso;

    // Both buttons at once cancel out and count as no activity
    assign evento    = aumentar ^ disminuir;
    assign base_paso = (estado_q == REPOSO) ? actual_q : edit_q;

    paso_acotado #(
        .ANCHO     (ANCHO),
        .VALOR_MIN (VALOR_MIN),
        .VALOR_MAX (VALOR_MAX)
    ) u_paso (
        .valor     (base_paso),
        .subir     (aumentar),
        .resultado (valor_paso)
    );

    // State and value registers; reset abandons any edit in progress
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q <= REPOSO;
            actual_q <= RESET_V;
            edit_q   <= RESET_V;
            timer_q  <= '0;
            act_q    <= 1'b0;
        end else begin
            estado_q <= estado_sig;
            actual_q <= actual_sig;
            edit_q   <= edit_sig;
            timer_q  <= timer_sig;
            act_q    <= act_sig;
        end
    end

    // Next state: confirm beats adjust, adjust beats timeout
    always_comb begin
        estado_sig = estado_q;
        actual_sig = actual_q;
        edit_sig   = edit_q;
        timer_sig  = timer_q;
        act_sig    = 1'b0;
        case (estado_q)
            REPOSO: begin
                edit_sig  = actual_q;
                timer_sig = '0;
                if (evento) begin
                    edit_sig   = valor_paso;
                    estado_sig = EDICION;
                end
            end
            EDICION: begin
                if (confirmar) begin
                    actual_sig = edit_q;
                    estado_sig = REPOSO;
                    act_sig    = 1'b1;
                    timer_sig  = '0;
                end else if (evento) begin
                    edit_sig  = valor_paso;
                    timer_sig = '0;
                end else if (timer_q == TIMER_FIN) begin
                    edit_sig   = actual_q;
                    estado_sig = REPOSO;
                    timer_sig  = '0;
                end else begin
                    timer_sig = timer_q + 1'b1;
                end
            end
            default: begin
                estado_sig = REPOSO;
                edit_sig   = actual_q;
                timer_sig  = '0;
            end
        endcase
    end

    assign valor_actual = actual_q;
    assign valor_edit   = edit_q;
    assign editando     = (estado_q == EDICION);
    assign actualizado  = act_q;

endmodule

// File: tb/tb_control_ajuste_valor.sv
// tb/tb_control_ajuste_valor.sv - directed self-checking bench for control_ajuste_valor (expectations follow WRAP_AROUND_EN)
module tb_control_ajuste_valor;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       aumentar = 1'b0;
    logic       disminuir = 1'b0;
    logic       confirmar = 1'b0;
    logic [7:0] valor_actual;
    logic [7:0] valor_edit;
    logic       editando;
    logic       actualizado;

    int checks = 0;
    int errors = 0;

    control_ajuste_valor #(
        .ANCHO          (8),
        .VALOR_MIN      (0),
        .VALOR_MAX      (59),
        .VALOR_RESET    (0),
        .TIMEOUT_CICLOS (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .aumentar     (aumentar),
        .disminuir    (disminuir),
        .confirmar    (confirmar),
        .valor_actual (valor_actual),
        .valor_edit   (valor_edit),
        .editando     (editando),
        .actualizado  (actualizado)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge: drive inputs for one rising edge, return at the next negedge
    task automatic step(input logic a, input logic d, input logic c);
        aumentar  = a;
        disminuir = d;
        confirmar = c;
        @(negedge clk);
        aumentar  = 1'b0;
        disminuir = 1'b0;
        confirmar = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Reset, count up from 0 to v with consecutive presses, then confirm
    task automatic set_valor(input int v);
        do_reset();
        for (int i = 0; i < v; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_actual", 32'(valor_actual), 0);
        chk("rst_edit", 32'(valor_edit), 0);
        chk("rst_editando", 32'(editando), 0);
        chk("rst_actualizado", 32'(actualizado), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Confirm alone in REPOSO is ignored
        step(1'b0, 1'b0, 1'b1);
        chk("idle_confirm_editando", 32'(editando), 0);
        chk("idle_confirm_actualizado", 32'(actualizado), 0);

        // Three increments five cycles apart, then commit
        step(1'b1, 1'b0, 1'b0);
        chk("inc1_edit", 32'(valor_edit), 1);
        chk("inc1_editando", 32'(editando), 1);
        chk("inc1_actual", 32'(valor_actual), 0);
        idle(4);
        step(1'b1, 1'b0, 1'b0);
        chk("inc2_edit", 32'(valor_edit), 2);
        idle(4);
        step(1'b1, 1'b0, 1'b0);
        chk("inc3_edit", 32'(valor_edit), 3);
        idle(4);
        step(1'b0, 1'b0, 1'b1);
        chk("commit_actual", 32'(valor_actual), 3);
        chk("commit_actualizado", 32'(actualizado), 1);
        chk("commit_editando", 32'(editando), 0);
        idle(1);
        chk("commit_pulse_end", 32'(actualizado), 0);
        chk("commit_hold", 32'(valor_actual), 3);

        // Upper edge
        set_valor(58);
        chk("c58_actual", 32'(valor_actual), 58);
        step(1'b1, 1'b0, 1'b0);
        chk("top_a", 32'(valor_edit), 59);
        step(1'b1, 1'b0, 1'b0);
`ifdef WRAP_AROUND_EN
        chk("top_b", 32'(valor_edit), 0);
`else
        chk("top_b", 32'(valor_edit), 59);
`endif
        step(1'b1, 1'b0, 1'b0);
`ifdef WRAP_AROUND_EN
        chk("top_c", 32'(valor_edit), 1);
`else
        chk("top_c", 32'(valor_edit), 59);
`endif

        // Lower edge
        do_reset();
        step(1'b0, 1'b1, 1'b0);
`ifdef WRAP_AROUND_EN
        chk("bot_edit", 32'(valor_edit), 59);
`else
        chk("bot_edit", 32'(valor_edit), 0);
`endif
        chk("bot_editando", 32'(editando), 1);

        // Timeout discards the edit
        set_valor(10);
        step(1'b1, 1'b0, 1'b0);
        chk("to_edit", 32'(valor_edit), 11);
        idle(15);
        chk("to_still_editing", 32'(editando), 1);
        idle(1);
        chk("to_editando", 32'(editando), 0);
        chk("to_edit_restored", 32'(valor_edit), 10);
        chk("to_actual", 32'(valor_actual), 10);
        chk("to_no_pulse", 32'(actualizado), 0);

        // A press on the 15th idle cycle reloads the timer
        step(1'b1, 1'b0, 1'b0);
        idle(14);
        step(1'b1, 1'b0, 1'b0);
        chk("reload_edit", 32'(valor_edit), 12);
        idle(15);
        chk("reload_still_editing", 32'(editando), 1);
        chk("reload_edit_kept", 32'(valor_edit), 12);
        idle(1);
        chk("reload_timeout", 32'(editando), 0);
        chk("reload_edit_restored", 32'(valor_edit), 10);

        // Simultaneous inputs
        set_valor(4);
        step(1'b1, 1'b0, 1'b0);
        chk("sim_start", 32'(valor_edit), 5);
        step(1'b1, 1'b1, 1'b0);
        chk("both_edit", 32'(valor_edit), 5);
        chk("both_editando", 32'(editando), 1);
        step(1'b1, 1'b0, 1'b1);
        chk("conf_prio_actual", 32'(valor_actual), 5);
        chk("conf_prio_edit", 32'(valor_edit), 5);
        chk("conf_prio_pulse", 32'(actualizado), 1);

        // Asynchronous reset mid-edit
        set_valor(4);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("pre_rst_edit", 32'(valor_edit), 7);
        chk("pre_rst_actual", 32'(valor_actual), 4);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_actual", 32'(valor_actual), 0);
        chk("arst_edit", 32'(valor_edit), 0);
        chk("arst_editando", 32'(editando), 0);
        chk("arst_actualizado", 32'(actualizado), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_actual", 32'(valor_actual), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_ajuste_valor.md
Name: control_ajuste_valor

Overview:
- Consumes the single-cycle `aumentar` / `disminuir` / `confirmar` pulses produced by the button debounce/metastability front-ends.
- Holds a committed setting, such as a clock/timer field, plus an edit copy.
- An FSM enters edit mode on the first adjust pulse, steps the edit copy within [VALOR_MIN, VALOR_MAX], commits on `confirmar`, and discards the edit after an inactivity timeout.
- Sits between the button front-ends and the display/RTC write logic.

Parameters:
ANCHO, 8, width of the value registers
VALOR_MIN, 0, lowest legal value
VALOR_MAX, 59, highest legal value (VALOR_MIN < VALOR_MAX < 2^ANCHO)
VALOR_RESET, 0, committed value after reset (must lie within range)
TIMEOUT_CICLOS, 100000000, inactivity cycles before edit abandoned (≥2)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
aumentar  input  1  single-cycle increment pulse
disminuir  input  1  single-cycle decrement pulse
confirmar  input  1  single-cycle commit pulse
valor_actual  output  ANCHO  committed value
valor_edit  output  ANCHO  value being edited (equals valor_actual in REPOSO)
editando  output  1  high while in EDICION
actualizado  output  1  one-cycle pulse the cycle after a commit

Behaviour:
- Reset (async assert, sync deassert expected upstream) drives these values:
  - FSM to REPOSO.
  - `valor_actual` = `valor_edit` = VALOR_RESET.
  - `editando` = 0, `actualizado` = 0.
  - Timeout counter = 0.
- An "adjust event" is `aumentar` XOR `disminuir`. If both are high in the same cycle, it is not an event: no change and no timer reload.
- REPOSO:
  - On an adjust event: load `valor_edit` = `valor_actual` stepped by ±1 in the same cycle, go to EDICION, timer = 0.
  - `confirmar` alone: ignored.
- EDICION:
  - On an adjust event: step `valor_edit` and clear the timer.
  - With no event: timer increments.
  - When the timer reaches TIMEOUT_CICLOS−1 with no event: go to REPOSO and set `valor_edit` = `valor_actual` (edit discarded, no `actualizado`).
  - On `confirmar`: `valor_actual` <= `valor_edit`, go to REPOSO, and pulse `actualizado` for exactly 1 cycle in the cycle after the commit edge.
  - `confirmar` has priority over a simultaneous adjust event, which is dropped. `confirmar` also has priority over timeout in the same cycle.
- Registered-output latency: 1 clock from pulse to visible `valor_edit` / `valor_actual` change.
- Step arithmetic is computed at ANCHO+1 bits, with no intermediate overflow:
  - Increment at VALOR_MAX saturates at VALOR_MAX.
  - Decrement at VALOR_MIN saturates at VALOR_MIN.
- `editando` = 1 exactly while the state is EDICION.
- Reset asserted mid-edit aborts immediately. `valor_actual` returns to VALOR_RESET; no pulse.

Optional Feature:
WRAP_AROUND_EN
- Defined: range edges wrap. Increment at VALOR_MAX gives VALOR_MIN; decrement at VALOR_MIN gives VALOR_MAX.
- Undefined: saturating behaviour as above.
- All other behaviour is identical in both builds.

Decomposition:
- Shared package `ajuste_pkg`:
  - FSM state enum (REPOSO, EDICION).
  - Localparam function for the timer width, ceil(log2(TIMEOUT_CICLOS)).
- One natural sub-module, `paso_acotado`: combinational ±1 step with saturate/wrap, parameterised by ANCHO / VALOR_MIN / VALOR_MAX, and the only place WRAP_AROUND_EN is tested.
- Timer and FSM remain in the top module.

Test Plan (TIMEOUT_CICLOS=16, range 0..59, VALOR_RESET=0):
- Reset, then 3 `aumentar` pulses 5 cycles apart, then `confirmar`: `valor_edit` goes 1, 2, 3; `editando` = 1; after confirm `valor_actual` = 3, `actualizado` high exactly 1 cycle, `editando` = 0.
- Commit 58, then 3 `aumentar`:
  - Saturating build: `valor_edit` = 59, 59, 59.
  - WRAP_AROUND_EN build: 59, 0, 1.
- From 0, `disminuir`:
  - Saturating build: `valor_edit` = 0, and `editando` = 1.
  - WRAP build: 59.
- Commit 10, one `aumentar`, then no input for 16 cycles: returns to REPOSO with `valor_edit` = 10, `valor_actual` = 10, no `actualizado` pulse. A pulse at cycle 15 must reload the timer.
- In EDICION with `valor_edit` = 5:
  - `aumentar` and `disminuir` in the same cycle: no change.
  - `confirmar` and `aumentar` in the same cycle: commits 5, not 6.
- Assert `reset` asynchronously mid-edit (`valor_edit` = 7, `valor_actual` = 4): outputs go to VALOR_RESET / 0 immediately, before the next clk edge.
